// File: rtl/clock_pkg.sv
// Shared encodings for the clock core: set-mode status codes and the
// digit-enable masks that select which display field is being edited.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_TIME   = 3'd0,
    ST_HOUR   = 3'd1,
    ST_MINUTE = 3'd2,
    ST_MONTH  = 3'd3,
    ST_DAY    = 3'd4
  } status_t;

  localparam logic [3:0] MASK_TIME   = 4'b1111;
  localparam logic [3:0] MASK_HOUR   = 4'b1100;
  localparam logic [3:0] MASK_MINUTE = 4'b0011;
  localparam logic [3:0] MASK_MONTH  = 4'b1100;
  localparam logic [3:0] MASK_DAY    = 4'b0011;

  function automatic logic [3:0] field_mask(input status_t s);
    logic [3:0] m;
    case (s)
      ST_HOUR:   m = MASK_HOUR;
      ST_MINUTE: m = MASK_MINUTE;
      ST_MONTH:  m = MASK_MONTH;
      ST_DAY:    m = MASK_DAY;
      default:   m = MASK_TIME;
    endcase
    return m;
  endfunction

  function automatic status_t next_mode(input status_t s);
    status_t n;
    case (s)
      ST_TIME:   n = ST_HOUR;
      ST_HOUR:   n = ST_MINUTE;
      ST_MINUTE: n = ST_MONTH;
      ST_MONTH:  n = ST_DAY;
      default:   n = ST_TIME;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Hold-to-repeat for the add key: one fire per press, then one after
// REPEAT_DELAY held ticks and one every REPEAT_RATE ticks after that.
module key_repeat #(
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic pulse,
  input  logic held,
  input  logic tick_10ms,
  output logic fire
);

  localparam int DW = $clog2(REPEAT_DELAY + 1);
  localparam int RW = (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE) : 1;
  localparam logic [DW-1:0] DELAY_MAX  = DW'(REPEAT_DELAY);
  localparam logic [DW-1:0] DELAY_LAST = DW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [DW-1:0] hold_cnt;
  logic [RW-1:0] rate_cnt;
  logic          armed;
  logic          delay_hit;
  logic          rate_hit;

  // hold_cnt saturates at the delay; rate_cnt only runs once armed
  assign armed     = (hold_cnt == DELAY_MAX);
  assign delay_hit = held && tick_10ms && (hold_cnt == DELAY_LAST);
  assign rate_hit  = held && tick_10ms && armed && (rate_cnt == RATE_LAST);
  assign fire      = !clear && (pulse || delay_hit || rate_hit);

  always_ff @(posedge clock) begin
    if (!reset || clear || !held) begin
      hold_cnt <= '0;
      rate_cnt <= '0;
    end else if (tick_10ms) begin
      if (!armed) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else if (rate_cnt == RATE_LAST) begin
        rate_cnt <= '0;
      end else begin
        rate_cnt <= rate_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/set_mode_ctrl.sv
// Time-setting sequencer: mode FSM, add-key increments with auto-repeat,
// idle timeout, blink mask and seconds-chain run/clear control.
module set_mode_ctrl
  import clock_pkg::*;
#(
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int IDLE_TIMEOUT = 10,
  parameter int BLINK_HALF   = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_10ms,
  input  logic       tick_1s,
  input  logic       key_mode_pulse,
  input  logic       key_add_pulse,
  input  logic       key_add_held,
  output logic [2:0] status,
  output logic       inc_minute,
  output logic       inc_hour,
  output logic       inc_day,
  output logic       inc_month,
  output logic       clock_run,
  output logic       sec_clear,
  output logic [3:0] digit_en
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  status_t       state;
  status_t       state_next;
  logic          dirty;
  logic          dirty_next;
  logic          phase;
  logic          phase_next;
  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] idle_next;
  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_next;

  logic          in_set;
  logic          rep_clear;
  logic          fire;
  logic          key_activity;
  logic          timeout;
  logic          enter_time;
  logic          inc_req;
  logic          inc_minute_next;
  logic          inc_hour_next;
  logic          inc_day_next;
  logic          inc_month_next;
  logic          run_next;
  logic          clear_next;
  logic [3:0]    digit_next;

  assign status       = state;
  assign in_set       = (state != ST_TIME);
  // a mode press always wins over add, and TIME ignores the add key
  assign rep_clear    = key_mode_pulse || !in_set;
  assign key_activity = key_mode_pulse || key_add_pulse || key_add_held;
  assign timeout      = in_set && tick_1s && !key_activity && (idle_cnt == IDLE_LAST);

  key_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_key_repeat (
    .clock    (clock),
    .reset    (reset),
    .clear    (rep_clear),
    .pulse    (key_add_pulse),
    .held     (key_add_held),
    .tick_10ms(tick_10ms),
    .fire     (fire)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_TIME;
      dirty      <= 1'b0;
      phase      <= 1'b0;
      idle_cnt   <= '0;
      blink_cnt  <= '0;
      inc_minute <= 1'b0;
      inc_hour   <= 1'b0;
      inc_day    <= 1'b0;
      inc_month  <= 1'b0;
      clock_run  <= 1'b1;
      sec_clear  <= 1'b0;
      digit_en   <= MASK_TIME;
    end else begin
      state      <= state_next;
      dirty      <= dirty_next;
      phase      <= phase_next;
      idle_cnt   <= idle_next;
      blink_cnt  <= blink_next;
      inc_minute <= inc_minute_next;
      inc_hour   <= inc_hour_next;
      inc_day    <= inc_day_next;
      inc_month  <= inc_month_next;
      clock_run  <= run_next;
      sec_clear  <= clear_next;
      digit_en   <= digit_next;
    end
  end

  always_comb begin
    state_next = state;
    if (key_mode_pulse) begin
      state_next = next_mode(state);
    end else if (timeout) begin
      state_next = ST_TIME;
    end
  end

  always_comb begin
    inc_req         = fire && in_set;
    enter_time      = in_set && (state_next == ST_TIME);
    inc_hour_next   = inc_req && (state == ST_HOUR);
    inc_minute_next = inc_req && (state == ST_MINUTE);
    inc_month_next  = inc_req && (state == ST_MONTH);
    inc_day_next    = inc_req && (state == ST_DAY);

    // an edit is committed by zeroing seconds as TIME is re-entered
    clear_next = enter_time && dirty;
    dirty_next = enter_time ? 1'b0 : (dirty || inc_req);
    run_next   = !(dirty_next && (state_next != ST_TIME));

    idle_next = idle_cnt;
    if ((state_next == ST_TIME) || key_activity) begin
      idle_next = '0;
    end else if (tick_1s) begin
      idle_next = idle_cnt + 1'b1;
    end

    blink_next = blink_cnt;
    phase_next = phase;
    if ((state_next != state) || (state_next == ST_TIME)) begin
      blink_next = '0;
      phase_next = 1'b0;
    end else if (tick_10ms) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_next = '0;
        phase_next = !phase;
      end else begin
        blink_next = blink_cnt + 1'b1;
      end
    end

    digit_next = (phase_next && !key_add_held) ? 4'b0000 : field_mask(state_next);
  end

endmodule
